// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encodings,
// opcode/funct values, ALU operation codes, mux select codes and the
// control-vector layout produced by mc_output_decode.
package mc_pkg;

    // FSM state encodings
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] EXEC_R   = 4'd3;
    localparam logic [3:0] WB_R     = 4'd4;
    localparam logic [3:0] EXEC_I   = 4'd5;
    localparam logic [3:0] WB_I     = 4'd6;
    localparam logic [3:0] MEM_ADDR = 4'd7;
    localparam logic [3:0] MEM_RD   = 4'd8;
    localparam logic [3:0] MEM_WR   = 4'd9;
    localparam logic [3:0] WB_MEM   = 4'd10;
    localparam logic [3:0] BRANCH   = 4'd11;
    localparam logic [3:0] JUMP     = 4'd12;
    localparam logic [3:0] JR       = 4'd13;
    localparam logic [3:0] ERROR    = 4'd14;

    // Opcodes (IR[31:26]) and the one funct value the sequencer cares about
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    // Register destination select
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // Write-back data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALU operand selects
    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_RS   = 1'b1;
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFF = 2'd3;

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Full datapath control vector
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    // States that own the memory port and therefore wait on mem_ready
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

    // Instruction class selected in DECODE; unknown encodings map to ERROR
    function automatic logic [3:0] decode_target(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] tgt;
        case (op)
            OP_RTYPE:                        tgt = (fn == FN_JR) ? JR : EXEC_R;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: tgt = EXEC_I;
            OP_LW, OP_SW:                    tgt = MEM_ADDR;
            OP_BEQ, OP_BNE:                  tgt = BRANCH;
            OP_J, OP_JAL:                    tgt = JUMP;
            default:                         tgt = ERROR;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode for the multi-cycle sequencer.
// Every control is a pure function of the state register (plus the latched
// opcode where one state serves several instructions); only the FETCH-cycle
// IR/PC loads are additionally qualified by mem_ready.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Map the current state to the datapath control vector
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                // IR and PC+4 are only committed once the word is delivered
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_BOFF;
                ctrl.alu_op    = ALU_ADD;
            end
            EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_LUI:  ctrl.alu_op = ALU_LUI;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_RS;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            BRANCH: begin
                // Compare rs-rt; the datapath gates the PC load with zero
                ctrl.alu_src_a   = SRCA_RS;
                ctrl.alu_src_b   = SRCB_RT;
                ctrl.alu_op      = ALU_SUB;
                ctrl.pc_source   = PCS_ALUOUT;
                ctrl.pc_write_eq = (opcode == OP_BEQ);
                ctrl.pc_write_ne = (opcode == OP_BNE);
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                if (opcode == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_RS;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer top. Holds the state register, the memory
// wait-state counter, the sticky error code and the retired-instruction
// counter; control outputs come from mc_output_decode.
// Optional build macro PERF_COUNT_EN adds live cycle/stall counters; without
// it cycle_count and stall_count are constant zero.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_eq,
    output logic             pc_write_ne,
    output logic [1:0]       pc_source,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state_out,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [7:0]       WAIT_LAST = 8'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic [1:0] err_code_nxt;
    logic       done;
    logic       stalled;
    logic       timeout;
    ctrl_t      ctrl;

    // The branch decision is applied in the datapath through pc_write_eq/ne,
    // so the sequencer itself never needs the zero flag.
    logic unused_zero;
    assign unused_zero = zero;

    // A memory state with no completion this cycle; the final permitted wait
    // cycle turns into a timeout unless mem_ready arrives in it.
    assign stalled = is_mem_state(state) && !mem_ready;
    assign timeout = stalled && (wait_cnt == WAIT_LAST);

    // Next-state selection, instruction retirement and error classification
    always_comb begin
        state_nxt    = state;
        err_code_nxt = err_code;
        done         = 1'b0;
        case (state)
            IDLE:     if (run) state_nxt = FETCH;
            FETCH:    if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                state_nxt = decode_target(opcode, funct);
                if (state_nxt == ERROR) err_code_nxt = ERR_ILLEGAL;
            end
            EXEC_R:   state_nxt = WB_R;
            EXEC_I:   state_nxt = WB_I;
            MEM_ADDR: state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_nxt = WB_MEM;
            MEM_WR:   if (mem_ready) done = 1'b1;
            WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR: done = 1'b1;
            ERROR:    state_nxt = ERROR;
            default:  state_nxt = IDLE;
        endcase
        // Instruction boundary: halt here if run has been dropped
        if (done) state_nxt = run ? FETCH : IDLE;
        if (timeout) begin
            state_nxt    = ERROR;
            err_code_nxt = ERR_TIMEOUT;
        end
    end

    // Wait counter runs only across consecutive stalled cycles of one state
    assign wait_cnt_nxt = (stalled && !timeout) ? (wait_cnt + 8'd1) : 8'd0;

    // State register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Error code latches on entry to ERROR and holds until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_code <= ERR_NONE;
        else       err_code <= err_code_nxt;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     instr_count <= '0;
        else if (done) instr_count <= instr_count + CNT_ONE;
    end

`ifdef PERF_COUNT_EN
    // Active-cycle counter: everything except IDLE and ERROR
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               cycle_count <= '0;
        else if (state != IDLE && state != ERROR) cycle_count <= cycle_count + CNT_ONE;
    end

    // Memory stall counter: memory-state cycles without mem_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        stall_count <= '0;
        else if (stalled) stall_count <= stall_count + CNT_ONE;
    end
`else
    assign cycle_count = '0;
    assign stall_count = '0;
`endif

    mc_output_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req     = ctrl.mem_req;
    assign mem_we      = ctrl.mem_we;
    assign i_or_d      = ctrl.i_or_d;
    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign pc_write_eq = ctrl.pc_write_eq;
    assign pc_write_ne = ctrl.pc_write_ne;
    assign pc_source   = ctrl.pc_source;
    assign reg_write   = ctrl.reg_write;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign state_out   = state;
    assign error       = (state == ERROR);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. It drives the PC, register file, ALU-source muxes, instruction register and a shared instruction/data memory port. Instructions execute over 3–5 states instead of a single cycle. Memory accesses use a req/ready handshake with wait-state tolerance and a timeout.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles a memory state waits with mem_ready low before entering ERROR (1..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE, clears counters
run  in  1  level; 1 = fetch/execute, 0 = halt after the current instruction
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid while mem_req=1
i_or_d  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_eq  out  1  PC load if zero=1
pc_write_ne  out  1  PC load if zero=0
pc_source  out  2  0 = ALU, 1 = ALUOut (branch), 2 = jump target, 3 = rs (jr)
reg_write  out  1  register-file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 R-type (funct), 011 or, 100 and, 101 lui
state_out  out  4  current state encoding
error  out  1  sticky; set in ERROR
err_code  out  2  0 none, 1 illegal opcode/funct, 2 memory timeout
instr_count  out  CNT_W  retired instructions

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are Moore decodes of the state register, except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- Reset: state=IDLE; all outputs 0; wait counter 0; error=0; err_code=0; instr_count=0. Reset mid-instruction aborts it immediately.
- IDLE: all controls 0. Go to FETCH when run=1.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0.
  - If mem_ready=1: ir_write=1, pc_write=1 (PC<=PC+4), go to DECODE.
  - Else stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Decode opcode:
  - 0x00 with funct 0x08 → JR
  - 0x00 otherwise → EXEC_R
  - 0x08 / 0x0D / 0x0C / 0x0F → EXEC_I
  - 0x23 / 0x2B → MEM_ADDR
  - 0x04 / 0x05 → BRANCH
  - 0x02 / 0x03 → JUMP
  - other → ERROR, err_code=1
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=010 → WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → DONE.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op = add(0x08) / or(0x0D) / and(0x0C) / lui(0x0F) → WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → DONE.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=add → MEM_RD (0x23) or MEM_WR (0x2B).
- MEM_RD: mem_req=1, i_or_d=1; on mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready go to DONE.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → DONE.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_source=1; pc_write_eq=1 (0x04) or pc_write_ne=1 (0x05) → DONE.
- JUMP: pc_write=1, pc_source=2; for 0x03 also reg_write=1, reg_dst=2, mem_to_reg=2 → DONE.
- JR: pc_write=1, pc_source=3 → DONE.
- DONE is a transition condition, not a state: instr_count+1 (wraps at 2^CNT_W), then next state is FETCH if run=1, else IDLE.
- Handshake:
  - mem_req, mem_we and i_or_d are held stable until the cycle mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - The wait counter increments each memory-state cycle with mem_ready=0 and clears on state exit.
  - When the counter reaches WAIT_LIMIT with mem_ready still 0: go to ERROR, err_code=2.
  - If mem_ready=1 arrives in the same cycle the limit is hit, mem_ready wins.
- ERROR: all controls 0, error=1. Sticky until reset; run is ignored.
- run falling mid-instruction: the instruction completes; the halt takes effect at DONE.
- Latency with mem_ready=1 on first request cycle:
  - beq/bne/j/jal/jr: 3 cycles
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - each memory wait cycle adds 1

Optional Feature:
PERF_COUNT_EN
- Defined: adds output cycle_count (CNT_W), incremented every non-IDLE, non-ERROR cycle, and output stall_count (CNT_W), incremented every memory-state cycle with mem_ready=0. Both clear on reset and wrap.
- Undefined: both ports are still present and tied to 0; no counter flops.

Decomposition:
- Package mc_pkg holds:
  - state encoding constants: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, JR, ERROR
  - opcode and funct constants
  - alu_op codes
  - pc_source / reg_dst / mem_to_reg codes
- Sub-module mc_output_decode: combinational state+opcode → control vector. The top keeps the state register, wait counter and counters.

Test Plan:
- Reset with run=1, opcode=0x00, funct=0x20, mem_ready tied 1 → states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 with reg_dst=1 in cycle 4; instr_count=1.
- opcode=0x23, mem_ready low 3 cycles in MEM_RD → mem_req held stable 4 cycles; WB_MEM follows; total 8 cycles; stall_count=3 when PERF_COUNT_EN is defined.
- opcode=0x05 with zero=0, then zero=1 → pc_write_ne=1 in BRANCH both times; pc_source=1; 3 cycles each.
- opcode=0x03 → JUMP: pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. opcode=0x00, funct=0x08 → JR with pc_source=3.
- opcode=0x3F → ERROR, err_code=1, error sticky across 10 cycles with run=1. mem_ready held 0 in FETCH → ERROR after 15 cycles, err_code=2.
- run dropped during EXEC_I → WB_I completes, then IDLE. Reset asserted mid-MEM_WR → mem_req=0 immediately, state=IDLE, counters 0.
